// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Shares one single-ported data memory between the CPU load/store path
//   (port 0) and a secondary master such as DMA or a debug loader (port 1).
//   At most one port is granted per cycle. Ties are broken round-robin. A
//   port may lock ownership for a burst, but it is forced to yield after
//   MAX_HOLD consecutive locked grants if the other port is waiting.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   reqN/lockN/weN         request, burst lock, write(1)/read(0) for port N
//   addrN/wdN              byte address and write data for port N
//   gntN                   combinational grant; the access completes at the edge
//   rdataN/rvalidN         registered read data and one-cycle valid strobe
//   mem_we/mem_re          memory write/read enables (combinational)
//   mem_addr/mem_wd        memory address/write data (0 when idle)
//   mem_rd                 combinational memory read data
module dm_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata0_q, rdata1_q;
  logic             rvalid0_q, rvalid1_q;
  logic             sel0, sel1;
  logic             at_max;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(MAX_HOLD)) return CNT_W'(MAX_HOLD);
    else                       return c + CNT_W'(1);
  endfunction

  assign at_max = (cnt_q == CNT_W'(MAX_HOLD));

  // Grant selection: owner keeps the grant unless it has used up its hold
  // budget while the other port waits; otherwise round-robin on a tie.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (owner_q == OWN_P0 && req0 && !(at_max && req1)) begin
      sel0 = 1'b1;
    end else if (owner_q == OWN_P1 && req1 && !(at_max && req0)) begin
      sel1 = 1'b1;
    end else if (owner_q == OWN_P0 && req0) begin
      // forced release: the waiting port wins this cycle
      sel1 = 1'b1;
    end else if (owner_q == OWN_P1 && req1) begin
      sel0 = 1'b1;
    end else if (req0 && req1) begin
      sel0 = ~prio_q;
      sel1 = prio_q;
    end else begin
      sel0 = req0;
      sel1 = req1;
    end
  end

  // Gating with reset keeps the memory quiet while reset is held low.
  assign gnt0 = sel0 & reset;
  assign gnt1 = sel1 & reset;

  always_comb begin
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = 32'd0;
    mem_wd   = 32'd0;
    if (gnt0) begin
      mem_we   = we0;
      mem_re   = ~we0;
      mem_addr = addr0;
      mem_wd   = wd0;
    end else if (gnt1) begin
      mem_we   = we1;
      mem_re   = ~we1;
      mem_addr = addr1;
      mem_wd   = wd1;
    end
  end

  // Ownership/priority update. With no grant, any owner has dropped its
  // request, so ownership is released.
  always_comb begin
    owner_d = OWN_NONE;
    prio_d  = prio_q;
    cnt_d   = '0;
    if (gnt0) begin
      prio_d  = 1'b1;
      owner_d = lock0 ? OWN_P0 : OWN_NONE;
      cnt_d   = (owner_q == OWN_P0) ? sat_inc(cnt_q) : CNT_W'(1);
    end else if (gnt1) begin
      prio_d  = 1'b0;
      owner_d = lock1 ? OWN_P1 : OWN_NONE;
      cnt_d   = (owner_q == OWN_P1) ? sat_inc(cnt_q) : CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_NONE;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if (gnt0 & ~we0) rdata0_q <= mem_rd;
      if (gnt1 & ~we1) rdata1_q <= mem_rd;
    end
  end

  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
//   Directed bench for dm_arbiter. Stimulus pushes expected grants and read
//   returns into two queues; a monitor on the falling edge pops and compares
//   whenever the arbiter shows a grant or a read-valid strobe. A small word
//   memory model sits on the memory side of the arbiter.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic        gnt0, gnt1;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dm_arbiter #(.MAX_HOLD(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .lock0    (lock0),
    .lock1    (lock1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wd0      (wd0),
    .wd1      (wd1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  // Word memory model: combinational read, write at the grant edge.
  logic [31:0] mem [0:255];
  assign mem_rd = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

  typedef struct {
    int          cyc;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  exp_t ge, re;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  localparam logic [31:0] A1 = 32'hA0A0_0001;
  localparam logic [31:0] A2 = 32'hA0A0_0002;
  localparam logic [31:0] A3 = 32'hA0A0_0003;
  localparam logic [31:0] B1 = 32'hB1B1_0001;
  localparam logic [31:0] B2 = 32'hB1B1_0002;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%08h, required 0x%08h", nm, cyc, act, exp);
  endfunction

  task automatic exp_g(input int off, input int port, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + off; e.port = port; e.we = we; e.addr = a; e.data = d;
    gq.push_back(e);
  endtask

  task automatic exp_r(input int off, input int port, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + off; e.port = port; e.we = 1'b0; e.addr = 32'd0; e.data = d;
    rq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic r, input logic l, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    req0 = r; lock0 = l; we0 = w; addr0 = a; wd0 = d;
  endtask

  task automatic drv1(input logic r, input logic l, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    req1 = r; lock1 = l; we1 = w; addr1 = a; wd1 = d;
  endtask

  // Monitor: compare on the falling edge whenever the DUT shows activity.
  always @(negedge clk) begin
    if (reset) begin
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        n_chk++;
        $display("FAIL gnt_missed: port %0d expected in cycle %0d, got no grant", gq[0].port, gq[0].cyc);
        gq.delete(0);
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        n_chk++;
        $display("FAIL rvalid_missed: port %0d expected in cycle %0d, got no rvalid", rq[0].port, rq[0].cyc);
        rq.delete(0);
      end
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) begin
          n_chk++;
          $display("FAIL gnt_unexpected (cycle %0d): got gnt0=%0d gnt1=%0d, required none", cyc, gnt0, gnt1);
        end else begin
          ge = gq.pop_front();
          chk("gnt_cycle", 32'(cyc), 32'(ge.cyc));
          chk("gnt_port", 32'({gnt1, gnt0}), 32'(ge.port + 1));
          chk("mem_we", 32'(mem_we), 32'(ge.we));
          chk("mem_re", 32'(mem_re), 32'(!ge.we));
          chk("mem_addr", mem_addr, ge.addr);
          chk("mem_wd", mem_wd, ge.data);
        end
      end else begin
        chk("idle_bus", mem_addr | mem_wd | 32'({mem_we, mem_re}), 32'd0);
      end
      if (rvalid0 || rvalid1) begin
        if (rq.size() == 0) begin
          n_chk++;
          $display("FAIL rvalid_unexpected (cycle %0d): got rvalid0=%0d rvalid1=%0d, required none", cyc, rvalid0, rvalid1);
        end else begin
          re = rq.pop_front();
          chk("rvalid_cycle", 32'(cyc), 32'(re.cyc));
          chk("rvalid_port", 32'({rvalid1, rvalid0}), 32'(re.port + 1));
          chk("rdata", (re.port == 1) ? rdata1 : rdata0, re.data);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    reset = 1'b0;
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) step();

    // Reset: a write request must not reach the memory.
    drv0(1'b1, 1'b0, 1'b1, 32'h4, 32'h55);
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    step();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_no_write", mem[1], 32'd0);

    // Round-robin writes from both ports, port 0 first after reset.
    step();
    drv0(1'b1, 1'b0, 1'b1, 32'h20, A1);
    drv1(1'b1, 1'b0, 1'b1, 32'h24, B1);
    exp_g(0, 0, 1'b1, 32'h20, A1);
    step();
    drv0(1'b1, 1'b0, 1'b1, 32'h28, A2);
    exp_g(0, 1, 1'b1, 32'h24, B1);
    step();
    drv1(1'b1, 1'b0, 1'b1, 32'h2C, B2);
    exp_g(0, 0, 1'b1, 32'h28, A2);
    step();
    drv0(1'b1, 1'b0, 1'b1, 32'h30, A3);
    exp_g(0, 1, 1'b1, 32'h2C, B2);
    step();
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    exp_g(0, 0, 1'b1, 32'h30, A3);
    step();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Cross-port read-back; port 1 holds priority after port 0's last grant.
    step();
    drv0(1'b1, 1'b0, 1'b0, 32'h2C, 32'd0);
    drv1(1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
    exp_g(0, 1, 1'b0, 32'h20, 32'd0);
    exp_r(1, 1, A1);
    step();
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    exp_g(0, 0, 1'b0, 32'h2C, 32'd0);
    exp_r(1, 0, B2);
    step();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Single write then back-to-back read on port 0.
    step();
    drv0(1'b1, 1'b0, 1'b1, 32'h10, DB);
    exp_g(0, 0, 1'b1, 32'h10, DB);
    step();
    drv0(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
    exp_g(0, 0, 1'b0, 32'h10, 32'd0);
    exp_r(1, 0, DB);
    step();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Locked burst on port 1: 8 grants, then port 0 on the 9th cycle.
    step();
    drv1(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
    exp_g(0, 1, 1'b0, 32'h10, 32'd0);
    exp_r(1, 1, DB);
    for (int i = 1; i < 8; i++) begin
      step();
      if (i == 1) drv0(1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
      exp_g(0, 1, 1'b0, 32'h10, 32'd0);
      exp_r(1, 1, DB);
    end
    step();
    exp_g(0, 0, 1'b0, 32'h20, 32'd0);
    exp_r(1, 0, A1);
    step();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    exp_g(0, 1, 1'b0, 32'h10, 32'd0);
    exp_r(1, 1, DB);
    step();
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Lock release: locked owner drops its request, port 1 wins that cycle.
    step();
    drv0(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
    exp_g(0, 0, 1'b0, 32'h10, 32'd0);
    exp_r(1, 0, DB);
    step();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv1(1'b1, 1'b0, 1'b0, 32'h24, 32'd0);
    exp_g(0, 1, 1'b0, 32'h24, 32'd0);
    exp_r(1, 1, B1);
    step();
    drv0(1'b1, 1'b0, 1'b0, 32'h24, 32'd0);
    drv1(1'b1, 1'b0, 1'b0, 32'h28, 32'd0);
    exp_g(0, 0, 1'b0, 32'h24, 32'd0);
    exp_r(1, 0, B1);
    step();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    exp_g(0, 1, 1'b0, 32'h28, 32'd0);
    exp_r(1, 1, A2);
    step();
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset pulse in the middle of a locked port-1 burst.
    step();
    drv1(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
    exp_g(0, 1, 1'b0, 32'h10, 32'd0);
    exp_r(1, 1, DB);
    step();
    exp_g(0, 1, 1'b0, 32'h10, 32'd0);
    #6;
    reset = 1'b0;
    #1;
    chk("midrst_gnt1", 32'(gnt1), 32'd0);
    chk("midrst_mem_re", 32'(mem_re), 32'd0);
    chk("midrst_rvalid1", 32'(rvalid1), 32'd0);
    step();
    reset = 1'b1;
    drv0(1'b1, 1'b0, 1'b0, 32'h28, 32'd0);
    drv1(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
    exp_g(0, 0, 1'b0, 32'h28, 32'd0);
    exp_r(1, 0, A2);
    #2;
    chk("midrst_dropped_rvalid1", 32'(rvalid1), 32'd0);
    step();
    drv0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    exp_g(0, 1, 1'b0, 32'h10, 32'd0);
    exp_r(1, 1, DB);
    step();
    drv1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) step();

    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
